// File: rtl/ldpc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ldpc_pkg
//  Description : Shared constants and loader-state encoding for the BG1
//                layered LDPC decoder front end (LLR frame loader).
//  Contents    : LDPC_Z      lifting size (LLRs per APP row)
//                LDPC_LW     channel LLR width
//                LDPC_QW     APP word width per lane
//                LDPC_NCOL   base-graph columns (APP rows per frame)
//                LDPC_PUNCT  punctured leading columns
//                LDPC_AW     APP RAM address width
//                loader_state_e  loader FSM state encoding
//  Revision    : 1.0  initial release
// ============================================================================
package ldpc_pkg;

    localparam int LDPC_Z     = 384;
    localparam int LDPC_LW    = 5;
    localparam int LDPC_QW    = 6;
    localparam int LDPC_NCOL  = 68;
    localparam int LDPC_PUNCT = 2;
    localparam int LDPC_AW    = 7;

    typedef enum logic [1:0] {
        LS_IDLE = 2'd0,
        LS_ZERO = 2'd1,
        LS_LOAD = 2'd2,
        LS_DONE = 2'd3
    } loader_state_e;

endpackage : ldpc_pkg
`default_nettype wire

// File: rtl/llr_row_packer.sv
`default_nettype none
// ============================================================================
//  Module      : llr_row_packer
//  Description : Sign-extends each accepted LLR to the APP lane width and
//                shifts it into a Z-lane row register. The first LLR of a row
//                ends up in lane 0 once Z values have been shifted in.
//  Ports       : clk       clock
//                rst       synchronous active-high reset (clears row + count)
//                clear     restart the lane counter (frame start)
//                shift_en  accept llr_in this cycle
//                llr_in    LW-bit two's complement LLR
//                row_next  row register contents after this cycle's shift
//                row_full  this cycle's shift fills lane Z-1 (row complete)
//  Revision    : 1.0  initial release
// ============================================================================
module llr_row_packer
    import ldpc_pkg::*;
#(
    parameter int Z  = LDPC_Z,
    parameter int LW = LDPC_LW,
    parameter int QW = LDPC_QW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [LW-1:0]     llr_in,
    output logic [Z*QW-1:0]   row_next,
    output logic              row_full
);

    localparam int CW = $clog2(Z);

    logic [CW-1:0]   r_lane_cnt;
    logic [Z*QW-1:0] r_row;
    logic [QW-1:0]   w_llr_ext;

    assign w_llr_ext = {{(QW-LW){llr_in[LW-1]}}, llr_in};

    // New values enter at the top lane and everything moves down one lane,
    // so after Z shifts the oldest value sits in lane 0.
    assign row_next = {w_llr_ext, r_row[Z*QW-1:QW]};

    // Combinational so the owner can capture row_next on the completing shift
    // without an extra cycle of latency.
    assign row_full = shift_en && (r_lane_cnt == CW'(Z-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_cnt <= '0;
            r_row      <= '0;
        end else if (clear) begin
            r_lane_cnt <= '0;
        end else if (shift_en) begin
            r_row      <= row_next;
            r_lane_cnt <= row_full ? '0 : r_lane_cnt + CW'(1);
        end
    end

endmodule : llr_row_packer
`default_nettype wire

// File: rtl/llr_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : llr_frame_loader
//  Description : Channel-LLR input stage of the BG1 layered LDPC decoder.
//                Packs Z sign-extended LLRs per APP row and writes rows
//                PUNCT..NCOL-1 into APP RAM port A, then pulses load_done.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                new_fram          frame start pulse (honoured in IDLE only)
//                llr_in/llr_valid  channel LLR stream
//                llr_ready         registered accept indication
//                app_wr_en/addr/data  APP RAM port-A write (wea/addra/dina)
//                load_done         one-cycle pulse after the last row write
//                loading           frame in progress
//  Config      : LLR_PUNCT_ZERO_EN  when defined, rows 0..PUNCT-1 are written
//                with zeros before LLRs are accepted (requires PUNCT >= 1).
//  Revision    : 1.0  initial release
// ============================================================================
module llr_frame_loader
    import ldpc_pkg::*;
#(
    parameter int Z     = LDPC_Z,
    parameter int LW    = LDPC_LW,
    parameter int QW    = LDPC_QW,
    parameter int NCOL  = LDPC_NCOL,
    parameter int PUNCT = LDPC_PUNCT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_fram,
    input  logic [LW-1:0]      llr_in,
    input  logic               llr_valid,
    output logic               llr_ready,
    output logic               app_wr_en,
    output logic [LDPC_AW-1:0] app_wr_addr,
    output logic [Z*QW-1:0]    app_wr_data,
    output logic               load_done,
    output logic               loading
);

    localparam int AW = LDPC_AW;

    localparam logic [1:0] ST_IDLE = 2'(LS_IDLE);
`ifdef LLR_PUNCT_ZERO_EN
    localparam logic [1:0] ST_ZERO = 2'(LS_ZERO);
`endif
    localparam logic [1:0] ST_LOAD = 2'(LS_LOAD);
    localparam logic [1:0] ST_DONE = 2'(LS_DONE);

    logic [1:0]      r_state;
    logic [AW-1:0]   r_row_cnt;
    logic            w_accept;
    logic            w_start;
    logic            w_row_full;
    logic [Z*QW-1:0] w_row_next;

    assign w_accept = llr_valid && llr_ready;
    assign w_start  = (r_state == ST_IDLE) && new_fram;

    llr_row_packer #(
        .Z  (Z),
        .LW (LW),
        .QW (QW)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_start),
        .shift_en (w_accept),
        .llr_in   (llr_in),
        .row_next (w_row_next),
        .row_full (w_row_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_row_cnt   <= '0;
            llr_ready   <= 1'b0;
            app_wr_en   <= 1'b0;
            app_wr_addr <= '0;
            app_wr_data <= '0;
            load_done   <= 1'b0;
            loading     <= 1'b0;
        end else begin
            app_wr_en <= 1'b0;
            load_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    llr_ready <= 1'b0;
                    if (new_fram) begin
                        loading <= 1'b1;
`ifdef LLR_PUNCT_ZERO_EN
                        // Row 0 is written straight away so the zero phase
                        // takes exactly PUNCT cycles.
                        r_state     <= ST_ZERO;
                        app_wr_en   <= 1'b1;
                        app_wr_addr <= '0;
                        app_wr_data <= '0;
                        r_row_cnt   <= AW'(1);
`else
                        r_state   <= ST_LOAD;
                        r_row_cnt <= AW'(PUNCT);
                        llr_ready <= 1'b1;
`endif
                    end
                end
`ifdef LLR_PUNCT_ZERO_EN
                ST_ZERO: begin
                    if (r_row_cnt == AW'(PUNCT)) begin
                        r_state   <= ST_LOAD;
                        llr_ready <= 1'b1;
                    end else begin
                        app_wr_en   <= 1'b1;
                        app_wr_addr <= r_row_cnt;
                        app_wr_data <= '0;
                        r_row_cnt   <= r_row_cnt + AW'(1);
                    end
                end
`endif
                ST_LOAD: begin
                    llr_ready <= 1'b1;
                    if (w_row_full) begin
                        app_wr_en   <= 1'b1;
                        app_wr_addr <= r_row_cnt;
                        app_wr_data <= w_row_next;
                        r_row_cnt   <= r_row_cnt + AW'(1);
                        if (r_row_cnt == AW'(NCOL-1)) begin
                            r_state   <= ST_DONE;
                            llr_ready <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    load_done <= 1'b1;
                    loading   <= 1'b0;
                    llr_ready <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    llr_ready <= 1'b0;
                    loading   <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : llr_frame_loader
`default_nettype wire

// File: doc/llr_frame_loader.md
# llr_frame_loader

Upstream input stage of the 5G NR BG1 layered LDPC decoder: accepts the channel LLR stream one 5-bit value per handshake, sign-extends each to the 6-bit APP format, packs Z values into one 2304-bit row and writes that row into port A of the APP RAM. One frame covers every information and parity column of the base graph. When the last row is written, the block pulses `load_done`, which starts the decoder control FSM.

## Interface
Parameters:
- `Z`, 384: lifting size; LLRs per APP row.
- `LW`, 5: input LLR width, two's complement (-15..+15).
- `QW`, 6: APP word width per lane.
- `NCOL`, 68: base-graph columns (APP rows per frame).
- `PUNCT`, 2: punctured leading columns, which receive no channel LLRs.

Ports:
- `clk`  in  1  decoder clock.
- `rst`  in  1  synchronous, active-high reset.
- `new_fram`  in  1  single-cycle pulse that starts a frame load.
- `llr_in`  in  LW  channel LLR.
- `llr_valid`  in  1  `llr_in` is valid.
- `llr_ready`  out  1  loader accepts `llr_in` this cycle.
- `app_wr_en`  out  1  APP RAM port-A write enable (`wea`).
- `app_wr_addr`  out  7  APP RAM port-A address (`addra`).
- `app_wr_data`  out  Z*QW  APP RAM port-A data (`dina`); lane i occupies bits [i*QW+QW-1 : i*QW].
- `load_done`  out  1  one-cycle pulse after the final row write.
- `loading`  out  1  high from acceptance of `new_fram` until `load_done`.

## Operation
- FSM states: IDLE, ZERO, LOAD, DONE.
- **IDLE**
  - `llr_ready` = 0.
  - `new_fram` moves the FSM to ZERO when `LLR_PUNCT_ZERO_EN` is defined, otherwise to LOAD.
  - Clears the lane counter; sets the row counter to 0 (ZERO) or PUNCT (LOAD).
- **ZERO**
  - Writes all-zero data to rows 0..PUNCT-1, one row per cycle.
  - `llr_ready` = 0.
  - Then moves to LOAD with the row counter at PUNCT.
- **LOAD**
  - `llr_ready` = 1.
  - Each accepted LLR is sign-extended to QW bits and shifted into the lane register, first LLR into lane 0.
  - The lane counter counts 0..Z-1.
  - On the Z-th accepted LLR:
    - The completed row is copied into the output data register.
    - `app_wr_en` asserts on the next cycle at the current row.
    - The row counter increments and the lane counter wraps to 0.
  - Acceptance continues without a bubble.
  - After the write of row NCOL-1, the FSM moves to DONE.
- **DONE**
  - One cycle: `load_done` = 1, `loading` = 0 on the following cycle, return to IDLE.
- Accepted LLR count per frame: exactly (NCOL-PUNCT)*Z = 25344. Nothing outside LOAD is accepted.
- `new_fram` outside IDLE is ignored; the current frame continues unaffected.
- `llr_valid` gaps stall the lane counter. A partial row is held indefinitely.
- Reset, including mid-frame, returns the FSM to IDLE and discards any partial row. All outputs go to 0: `llr_ready`, `app_wr_en`, `app_wr_addr`, `app_wr_data`, `load_done`, `loading`.

## Timing
- Handshake: transfer when `llr_valid && llr_ready`. `llr_ready` is a registered state decode and does not depend on `llr_valid`.
- Row write latency: `app_wr_en` is high exactly one cycle, starting 1 cycle after the Z-th LLR of that row is accepted.
- Peak throughput: 1 LLR/cycle; a full frame with no stalls takes 25344 cycles.
- `load_done` rises 1 cycle after the final `app_wr_en`.
- ZERO state (macro on): PUNCT cycles, with one `app_wr_en` each. `llr_ready` rises the cycle after the last zero write.
- `new_fram` to first `llr_ready`:
  - 1 cycle with the macro off.
  - PUNCT+1 cycles with the macro on.
- All outputs are registered.

## Configuration
- `LLR_PUNCT_ZERO_EN`
  - Defined: the loader writes zero LLR rows to addresses 0..PUNCT-1 before accepting data, so punctured columns start at 0.
  - Undefined: the ZERO state is removed, rows 0..PUNCT-1 are never written by the loader, and the decoder's init path owns them.

## Structure
- Shared package `ldpc_pkg`: `Z`, `QW`, `NCOL`, `PUNCT`, APP address width (7), and a loader-state enum typedef.
- One natural sub-module: `llr_row_packer`. It holds the lane shift register, sign-extension and lane counter, and asserts `row_full` when lane Z-1 is filled.
- The FSM, row counter and output registers stay in `llr_frame_loader`.

## Test plan
- **Reset mid-LOAD:** assert `rst` after 1000 LLRs, then start a new frame.
  - All outputs are 0 one cycle after `rst`.
  - The next frame's first write is row 2 (or row 0 with the macro on) and contains only new LLRs.
- **Ramp frame, no stalls, macro off:** LLR k = (k mod 31) - 15.
  - 66 writes at addresses 2..67.
  - Row 2 lane 0 = 6'h31 (-15); lane 1 = 6'h32 (-14).
  - `load_done` occurs 25345 cycles after the first accept.
- **Macro on:**
  - Addresses 0 and 1 are written with all-zero data before `llr_ready` rises.
  - The remaining writes match the macro-off case.
- **Random `llr_valid` gaps (~30%):**
  - Written data matches the ramp case bit-exactly.
  - Exactly 66 `app_wr_en` pulses.
- **`new_fram` pulsed in mid-LOAD:**
  - Ignored; the write sequence is unchanged.
  - Exactly one `load_done`.
- **Extremes:** LLR values +15 and -15 in alternating lanes produce 6'h0F and 6'h31.
